// File: rtl/hr_pkg.sv
// hr_pkg: state encoding and word geometry shared by the HyperRAM read receiver
package hr_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, CAPT, DONE} hr_state_e;

    localparam int HR_WORD_W         = 32;
    localparam int HR_BEATS_PER_WORD = 2;

endpackage

// File: rtl/hr_iddr.sv
// hr_iddr: single-bit DDR input register, SAME_EDGE_PIPELINED (behavioural stand-in for IDDRE1)
module hr_iddr (
    input  logic clk,
    input  logic din,
    output logic dout_ris,
    output logic dout_fal
);

    logic ris_q, fal_q, ris_o_q, fal_o_q;

    // rising-edge sample, then both samples realigned onto the next rising edge
    always_ff @(posedge clk) begin
        ris_q   <= din;
        ris_o_q <= ris_q;
        fal_o_q <= fal_q;
    end

    // falling-edge sample
    always_ff @(negedge clk) fal_q <= din;

    assign dout_ris = ris_o_q;
    assign dout_fal = fal_o_q;

endmodule

// File: rtl/hr_rd_deser.sv
// hr_rd_deser: HyperRAM read-data receiver; DDR-samples DQ/RWDS and packs beat pairs into 32-bit words.
// Optional read abort on RWDS silence is built when HR_RD_TIMEOUT_EN is defined.
module hr_rd_deser #(
    parameter int DQ_W        = 8,
    parameter int LEN_W       = 8,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rd_start,
    input  logic [LEN_W-1:0] rd_len,
    input  logic [DQ_W-1:0]  dq_in,
    input  logic             rwds_in,
    output logic [31:0]      rd_d,
    output logic             rd_rdy,
    output logic             busy,
    output logic             rd_done,
    output logic             rd_timeout
);

    import hr_pkg::*;

    localparam int HALF_W = HR_WORD_W / HR_BEATS_PER_WORD;

    if (TIMEOUT_CYC < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be at least 2");
    end

    logic [DQ_W-1:0]      dq_ris, dq_fal;
    logic                 rwds_ris, rwds_fal, beat, accept, tmo_hit;
    hr_state_e            state_q, state_d;
    logic [LEN_W-1:0]     word_cnt_q, word_cnt_d;
    logic                 half_q, half_d;
    logic [HALF_W-1:0]    hw_q, hw_d;
    logic [HR_WORD_W-1:0] rd_d_q, rd_d_d;
    logic                 rd_rdy_q, rd_rdy_d, busy_q, busy_d, rd_done_q, rd_done_d;

    for (genvar i = 0; i < DQ_W; i++) begin : g_dq
        hr_iddr u_iddr (.clk(clk), .din(dq_in[i]), .dout_ris(dq_ris[i]), .dout_fal(dq_fal[i]));
    end

    hr_iddr u_rwds (.clk(clk), .din(rwds_in), .dout_ris(rwds_ris), .dout_fal(rwds_fal));

    assign beat   = rwds_ris & ~rwds_fal;
    assign accept = rd_start & ~busy_q;

`ifdef HR_RD_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC);

    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             active, rd_timeout_q;

    assign active  = state_q == WAIT || state_q == CAPT;
    assign tmo_hit = active && !beat && tmo_q == TMO_W'(TIMEOUT_CYC - 1);
    assign tmo_d   = (active && !beat) ? tmo_q + 1'b1 : '0;

    // silence counter and abort pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_q        <= '0;
            rd_timeout_q <= 1'b0;
        end else begin
            tmo_q        <= tmo_d;
            rd_timeout_q <= tmo_hit;
        end
    end

    assign rd_timeout = rd_timeout_q;
`else
    assign tmo_hit    = 1'b0;
    assign rd_timeout = 1'b0;
`endif

    // burst sequencing and half-word assembly
    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        half_d     = half_q;
        hw_d       = hw_q;
        rd_d_d     = rd_d_q;
        rd_rdy_d   = 1'b0;
        rd_done_d  = state_q == DONE;
        busy_d     = state_q != IDLE || accept;
        case (state_q)
            IDLE: if (accept) begin
                word_cnt_d = rd_len;
                half_d     = 1'b0;
                state_d    = rd_len == '0 ? DONE : WAIT;
            end
            WAIT: if (beat) begin
                hw_d    = {dq_ris, dq_fal};
                half_d  = 1'b1;
                state_d = CAPT;
            end
            CAPT: if (beat) begin
                half_d = ~half_q;
                if (!half_q) hw_d = {dq_ris, dq_fal};
                else begin
                    rd_d_d     = {hw_q, dq_ris, dq_fal};
                    rd_rdy_d   = 1'b1;
                    word_cnt_d = word_cnt_q != '0 ? word_cnt_q - 1'b1 : word_cnt_q;
                    state_d    = word_cnt_d == '0 ? DONE : CAPT;
                end
            end
            DONE: state_d = IDLE;
        endcase
        if (tmo_hit) begin
            state_d    = IDLE;
            word_cnt_d = '0;
            half_d     = 1'b0;
        end
    end

    // state and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            word_cnt_q <= '0;
            half_q     <= 1'b0;
            hw_q       <= '0;
            rd_d_q     <= '0;
            rd_rdy_q   <= 1'b0;
            busy_q     <= 1'b0;
            rd_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            half_q     <= half_d;
            hw_q       <= hw_d;
            rd_d_q     <= rd_d_d;
            rd_rdy_q   <= rd_rdy_d;
            busy_q     <= busy_d;
            rd_done_q  <= rd_done_d;
        end
    end

    assign rd_d    = rd_d_q;
    assign rd_rdy  = rd_rdy_q;
    assign busy    = busy_q;
    assign rd_done = rd_done_q;

endmodule

// File: tb/tb_hr_rd_deser.sv
// tb_hr_rd_deser: bench for hr_rd_deser; table of read bursts plus hand-timed corner sequences
module tb_hr_rd_deser;

    logic        clk = 1'b0, reset = 1'b1, rd_start = 1'b0, rwds_in = 1'b0;
    logic [7:0]  rd_len = 8'd0, dq_in = 8'd0;
    logic [31:0] rd_d;
    logic        rd_rdy, busy, rd_done, rd_timeout;

    int n_chk = 0, n_pass = 0, n_done = 0, n_rdy = 0, n_tmo = 0, exp_done = 0;
    logic [31:0] exp_q [$];

    typedef struct packed {
        logic [7:0]       len;
        logic [3:0][31:0] w;
        logic [3:0]       pre;
        logic [1:0]       midw;
        logic [3:0]       mid;
        logic             st11;
    } rd_vec_t;

    rd_vec_t tbl [4];

    hr_rd_deser dut (
        .clk(clk), .reset(reset), .rd_start(rd_start), .rd_len(rd_len),
        .dq_in(dq_in), .rwds_in(rwds_in), .rd_d(rd_d), .rd_rdy(rd_rdy),
        .busy(busy), .rd_done(rd_done), .rd_timeout(rd_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // scoreboard: every rd_rdy pops the oldest expected word
    always @(negedge clk) begin
        if (!reset) begin
            if (rd_rdy) begin
                n_rdy++;
                if (exp_q.size() == 0) chk("rdy_unexpected", 32'(rd_rdy), 32'd0);
                else chk("rd_d", rd_d, exp_q.pop_front());
            end
            if (rd_done) n_done++;
            if (rd_timeout) n_tmo++;
        end
    end

    // one DDR clock: r sampled on the rising edge, f on the following falling edge
    task automatic cyc(input logic [7:0] r, input logic [7:0] f, input logic wr, input logic wf);
        @(negedge clk); #1 dq_in = r; rwds_in = wr;
        @(posedge clk); #1 dq_in = f; rwds_in = wf;
    endtask

    task automatic start(input logic [7:0] len);
        @(negedge clk); #1 rd_start = 1'b1; rd_len = len; dq_in = 8'd0; rwds_in = 1'b0;
        @(posedge clk); #1 rd_start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int t;
        t = 0;
        @(negedge clk);
        while (!rd_done && t < 40) begin @(negedge clk); t++; end
        chk({name, "_done"}, 32'(rd_done), 32'd1);
        chk({name, "_busy_at_done"}, 32'(busy), 32'd1);
        chk({name, "_queue_drained"}, 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        chk({name, "_busy_off"}, 32'(busy), 32'd0);
    endtask

    function automatic rd_vec_t mk(input logic [7:0] len, input logic [31:0] w0, input logic [31:0] w1,
                                   input logic [31:0] w2, input logic [31:0] w3, input logic [3:0] pre,
                                   input logic [1:0] midw, input logic [3:0] mid, input logic st11);
        rd_vec_t v;
        v.len = len; v.w = {w3, w2, w1, w0}; v.pre = pre; v.midw = midw; v.mid = mid; v.st11 = st11;
        return v;
    endfunction

    initial begin
        logic [31:0] w;
        int r0, d0, t;
        tbl[0] = mk(8'd3, 32'h01020304, 32'h55AA55AA, 32'hDEADBEEF, 32'h0, 4'd2, 2'd0, 4'd2, 1'b1);
        tbl[1] = mk(8'd2, 32'h12345678, 32'h9ABCDEF0, 32'h0, 32'h0, 4'd0, 2'd1, 4'd1, 1'b0);
        tbl[2] = mk(8'd4, 32'hFFFFFFFF, 32'h00000000, 32'h80000001, 32'h7E7E7E7E, 4'd1, 2'd3, 4'd3, 1'b1);
        tbl[3] = mk(8'd1, 32'hCAFEF00D, 32'h0, 32'h0, 32'h0, 4'd5, 2'd0, 4'd0, 1'b0);

        repeat (2) @(negedge clk);
        chk("reset_rd_d", rd_d, 32'd0);
        chk("reset_rd_rdy", 32'(rd_rdy), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_rd_done", 32'(rd_done), 32'd0);
        chk("reset_rd_timeout", 32'(rd_timeout), 32'd0);
        reset = 1'b0;

        repeat (3) cyc(8'hEE, 8'hDD, 1'b1, 1'b0);
        repeat (3) cyc(8'h00, 8'h00, 1'b0, 1'b0);
        chk("idle_beats_busy", 32'(busy), 32'd0);
        chk("idle_beats_rdy", 32'(n_rdy), 32'd0);

        start(8'd1);
        repeat (3) cyc(8'hEE, 8'h77, 1'b0, 1'b0);
        cyc(8'hA1, 8'hB2, 1'b1, 1'b0);
        cyc(8'hC3, 8'hD4, 1'b1, 1'b0);
        exp_q.push_back(32'hA1B2C3D4);
        repeat (2) @(negedge clk);
        chk("w1_rdy_early", 32'(rd_rdy), 32'd0);
        @(negedge clk);
        chk("w1_rdy", 32'(rd_rdy), 32'd1);
        chk("w1_word", rd_d, 32'hA1B2C3D4);
        chk("w1_done_early", 32'(rd_done), 32'd0);
        @(negedge clk);
        chk("w1_done", 32'(rd_done), 32'd1);
        chk("w1_rdy_single", 32'(rd_rdy), 32'd0);
        chk("w1_busy_at_done", 32'(busy), 32'd1);
        chk("w1_rd_d_hold", rd_d, 32'hA1B2C3D4);
        @(negedge clk);
        chk("w1_busy_off", 32'(busy), 32'd0);
        chk("w1_done_single", 32'(rd_done), 32'd0);
        exp_done++;

        for (int i = 0; i < 4; i++) begin
            r0 = n_rdy;
            start(tbl[i].len);
            repeat (tbl[i].pre) cyc(8'hEE, 8'h77, tbl[i].st11, tbl[i].st11);
            for (int k = 0; k < int'(tbl[i].len); k++) begin
                w = tbl[i].w[k];
                cyc(w[31:24], w[23:16], 1'b1, 1'b0);
                if (k == int'(tbl[i].midw)) repeat (tbl[i].mid) cyc(8'hEE, 8'h77, tbl[i].st11, tbl[i].st11);
                cyc(w[15:8], w[7:0], 1'b1, 1'b0);
                exp_q.push_back(w);
            end
            wait_done("tbl");
            exp_done++;
            chk("tbl_rdy_count", 32'(n_rdy - r0), 32'(tbl[i].len));
        end

        r0 = n_rdy;
        start(8'd0);
        @(negedge clk);
        chk("len0_busy", 32'(busy), 32'd1);
        chk("len0_done_early", 32'(rd_done), 32'd0);
        @(negedge clk);
        chk("len0_done", 32'(rd_done), 32'd1);
        @(negedge clk);
        chk("len0_busy_off", 32'(busy), 32'd0);
        chk("len0_done_single", 32'(rd_done), 32'd0);
        chk("len0_no_rdy", 32'(n_rdy - r0), 32'd0);
        exp_done++;

        r0 = n_rdy;
        start(8'd2);
        cyc(8'h0A, 8'h0B, 1'b1, 1'b0);
        repeat (2) cyc(8'hEE, 8'h77, 1'b0, 1'b0);
        start(8'd5);
        cyc(8'h0C, 8'h0D, 1'b1, 1'b0);
        exp_q.push_back(32'h0A0B0C0D);
        cyc(8'h1A, 8'h1B, 1'b1, 1'b0);
        cyc(8'h1C, 8'h1D, 1'b1, 1'b0);
        exp_q.push_back(32'h1A1B1C1D);
        wait_done("busy_start");
        exp_done++;
        repeat (10) cyc(8'h00, 8'h00, 1'b0, 1'b0);
        chk("busy_start_ignored", 32'(busy), 32'd0);
        chk("busy_start_rdy_count", 32'(n_rdy - r0), 32'd2);

        r0 = n_rdy;
        d0 = n_done;
        start(8'd2);
        cyc(8'h11, 8'h22, 1'b1, 1'b0);
        cyc(8'h33, 8'h44, 1'b1, 1'b0);
        exp_q.push_back(32'h11223344);
        cyc(8'h55, 8'h66, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        chk("rst_pre_rdy", 32'(rd_rdy), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("rst_async_rd_d", rd_d, 32'd0);
        chk("rst_async_rd_rdy", 32'(rd_rdy), 32'd0);
        chk("rst_async_busy", 32'(busy), 32'd0);
        chk("rst_async_rd_done", 32'(rd_done), 32'd0);
        chk("rst_async_rd_timeout", 32'(rd_timeout), 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (8) cyc(8'h00, 8'h00, 1'b0, 1'b0);
        chk("rst_no_done", 32'(n_done - d0), 32'd0);
        chk("rst_no_late_rdy", 32'(n_rdy - r0), 32'd1);
        chk("rst_busy_idle", 32'(busy), 32'd0);

        r0 = n_rdy;
        start(8'd2);
        cyc(8'h5A, 8'hA5, 1'b1, 1'b0);
`ifdef HR_RD_TIMEOUT_EN
        t = 0;
        while (!rd_timeout && t < 200) begin @(negedge clk); t++; end
        chk("tmo_latency", 32'(t), 32'd67);
        chk("tmo_busy_at_pulse", 32'(busy), 32'd1);
        @(negedge clk);
        chk("tmo_busy_off", 32'(busy), 32'd0);
        chk("tmo_single", 32'(rd_timeout), 32'd0);
        chk("tmo_count", 32'(n_tmo), 32'd1);
`else
        t = 0;
        repeat (200) @(negedge clk);
        chk("no_tmo_busy_held", 32'(busy), 32'd1);
        chk("no_tmo_pulse", 32'(n_tmo + t), 32'd0);
`endif
        chk("tmo_no_rdy", 32'(n_rdy - r0), 32'd0);
        chk("done_total", 32'(n_done), 32'(exp_done));
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
